pool_layer_sched: RTL and testbench
===================================

Name: pool_layer_sched

Overview:
- Per-layer sequencer for the 8-lane ReLU/max-pool datapath. It sits between the conv PE array output and the feature-map output buffer.
- Latches the layer configuration and gates the PE valid stream into the pool array's data-in-start.
- Counts input and pooled pixels, and generates output-buffer write enables and addresses.
- Signals completion or error for each output-channel group.

Parameters:
- PE_NUM, 8, lanes in the pool array; all lanes are serviced in lock-step.
- ADDR_W, 10, output buffer address width.
- MAX_FEAT, 28, largest accepted input feature-map side.
- WDOG_MULT, 4, drain watchdog limit multiplier (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to run one channel group.
- cfg_featmap_size  in  5  input map side N.
- cfg_layer  in  1  0 = pool layer, 1 = bypass (pool array idle).
- cfg_out_base  in  ADDR_W  first output buffer address.
- pe_valid  in  1  conv PE array presents one pixel (all lanes) this cycle.
- pool_din_st  out  1  data-in-start to the pool array.
- pool_featmap_size  out  5  registered N to the pool array.
- pool_convlayer_state  out  1  registered cfg_layer to the pool array.
- pool_dout_st  in  1  pool array presents one pooled pixel (all lanes) this cycle.
- wr_en  out  1  output buffer write strobe.
- wr_addr  out  ADDR_W  output buffer address.
- busy  out  1  high from the cycle after an accepted start through DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset: state=IDLE. All outputs 0; pool_featmap_size=0; counters 0.
- Reset mid-run: everything returns to reset values on the next clk edge. No done or err pulse is issued.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with a valid config: latch the config, clear counters, go to RUN.
  - Valid config means N even and 2<=N<=MAX_FEAT.
  - start=1 with an invalid config: pulse err next cycle, stay in IDLE, latch nothing.
  - start outside IDLE is ignored.
- RUN:
  - pool_din_st = pe_valid && (cfg_layer==0); combinational, gated by state.
  - in_cnt increments on each pe_valid.
  - When pe_valid occurs with in_cnt==N*N-1, the next state is DRAIN. A later pe_valid is ignored and not forwarded.
- Output side (RUN and DRAIN):
  - Pool mode: wr_en = pool_dout_st.
  - Bypass mode: wr_en = pe_valid.
  - wr_addr = cfg_out_base + out_cnt, with ADDR_W wrap-around modulo 2^ADDR_W.
  - out_cnt increments on every wr_en.
  - Expected outputs: (N/2)^2 in pool mode, N*N in bypass.
- Completion:
  - When out_cnt reaches the expected count (the last write may occur in RUN or DRAIN), go to DONE next cycle.
  - Bypass completes directly from RUN on the final pe_valid.
- Stray outputs: pool_dout_st beyond the expected count, or while IDLE, produces no wr_en.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- Arithmetic:
  - N*N needs 10 bits; counters are 10 bits, unsigned.
  - Address sum is ADDR_W bits; carry is discarded.
- Simultaneous pe_valid and pool_dout_st in the same cycle: both counters update in that cycle.

Optional Feature:
- Macro: POOL_SCHED_WDOG_EN.
- Defined:
  - In DRAIN, a cycle counter resets on each pool_dout_st.
  - If the counter reaches WDOG_MULT*N, pulse err, drop busy, and return to IDLE. No done pulse is issued.
- Undefined:
  - No counter is built; DRAIN waits indefinitely.
  - err pulses only for an invalid config.

Decomposition:
- Package pool_sched_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - CNT_W=10;
  - function expected_outputs(N, layer);
  - function cfg_valid(N).
- Sub-module pool_sched_addr_gen: out_cnt, wr_addr adder and terminal-count compare. It is the natural reuse point for conv-output writeback.

Test Plan:
- Pool mode, N=4, base=0x100:
  - Stimulus: start, then 16 pe_valid back-to-back; model the pool array with pool_dout_st two cycles after each completed 2x2 window.
  - Required: pool_din_st high for exactly 16 cycles; 4 wr_en at 0x100–0x103; done one cycle after the 4th write; busy falls with done.
- Bypass, N=2, base=0x3FE:
  - Stimulus: 4 pe_valid.
  - Required: pool_din_st never high; wr_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; done follows.
- Invalid config:
  - Stimulus: start with N=5, then start with N=30.
  - Required: err pulse each time; busy stays 0; no wr_en.
- Reset mid-run:
  - Stimulus: N=28; deassert rst_n after 100 pe_valid; release; start again with N=2.
  - Required: all outputs 0 during reset; second run completes normally with 1 write at base.
- Stray and overlap:
  - Stimulus: pool_dout_st in IDLE; start during RUN; pe_valid after the last input.
  - Required: no wr_en, the start is ignored, and no pool_din_st is issued.
- Watchdog (POOL_SCHED_WDOG_EN), N=4:
  - Stimulus: withhold pool_dout_st after all inputs.
  - Required: err exactly 16 cycles after entering DRAIN; no done.

Source files
------------

// File: rtl/pool_sched_pkg.sv
// pool_sched_pkg: shared types, widths and config helpers for the pool layer scheduler
// Contents: state_t (IDLE/RUN/DRAIN/DONE), CNT_W, PE_NUM, WDOG_MULT, expected_outputs(), cfg_valid()
package pool_sched_pkg;
  localparam int PE_NUM = 8;
  localparam int WDOG_MULT = 4;
  localparam int CNT_W = 10;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  // Writes per group: (N/2)^2 pooled pixels, or N*N pass-through pixels in bypass
  function automatic logic [CNT_W-1:0] expected_outputs(input logic [4:0] n, input logic layer);
    return layer ? CNT_W'(n) * CNT_W'(n) : CNT_W'(n[4:1]) * CNT_W'(n[4:1]);
  endfunction
  function automatic logic cfg_valid(input logic [4:0] n, input int max_feat);
    return !n[0] && n >= 5'd2 && int'(n) <= max_feat;
  endfunction
endpackage

// File: rtl/pool_sched_addr_gen.sv
// pool_sched_addr_gen: output write counter, base+count address and terminal-count compare
// Ports: clk, rst_n (sync, active low), clr (restart count), inc (one write this cycle),
//        base, expected (writes per group) in; addr, last (current write is final), full out
module pool_sched_addr_gen
  import pool_sched_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  expected,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              full
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (inc) cnt <= cnt + CNT_W'(1);
  // Carry out of the address sum is dropped so the buffer wraps
  assign addr = base + ADDR_W'(cnt);
  assign last = cnt == expected - CNT_W'(1);
  assign full = cnt >= expected;
endmodule

// File: rtl/pool_layer_sched.sv
// pool_layer_sched: per-channel-group sequencer between the conv PE array and the output buffer
// Ports: clk, rst_n (sync, active low); start, cfg_featmap_size, cfg_layer, cfg_out_base in;
//        pe_valid in, pool_din_st/pool_featmap_size/pool_convlayer_state out to the pool array;
//        pool_dout_st in; wr_en, wr_addr to the output buffer; busy, done, err status out.
// Option: POOL_SCHED_WDOG_EN builds a DRAIN watchdog that aborts with err after WDOG_MULT*N idle cycles.
module pool_layer_sched
  import pool_sched_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int MAX_FEAT = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        cfg_featmap_size,
  input  logic              cfg_layer,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic              pe_valid,
  output logic              pool_din_st,
  output logic [4:0]        pool_featmap_size,
  output logic              pool_convlayer_state,
  input  logic              pool_dout_st,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0] in_cnt, nn;
  logic err_q, ok, accept, run, act, last_in, last, full, wdog_to;
  assign ok = cfg_valid(cfg_featmap_size, MAX_FEAT);
  assign accept = state == IDLE && start && ok;
  assign run = state == RUN;
  assign act = run || state == DRAIN;
  assign nn = CNT_W'(pool_featmap_size) * CNT_W'(pool_featmap_size);
  assign last_in = run && pe_valid && in_cnt == nn - CNT_W'(1);
  assign err = err_q;
  pool_sched_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk(clk),
    .rst_n(rst_n),
    .clr(accept),
    .inc(wr_en),
    .base(base_q),
    .expected(expected_outputs(pool_featmap_size, pool_convlayer_state)),
    .addr(wr_addr),
    .last(last),
    .full(full)
  );
`ifdef POOL_SCHED_WDOG_EN
  logic [CNT_W-1:0] wd_cnt;
  always_ff @(posedge clk)
    if (!rst_n || state != DRAIN || pool_dout_st) wd_cnt <= '0;
    else wd_cnt <= wd_cnt + CNT_W'(1);
  // Fires on the WDOG_MULT*N-th consecutive idle DRAIN cycle
  assign wdog_to = state == DRAIN && !pool_dout_st &&
                   wd_cnt == CNT_W'(WDOG_MULT) * CNT_W'(pool_featmap_size) - CNT_W'(1);
`else
  assign wdog_to = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    pool_din_st = run && pe_valid && !pool_convlayer_state;
    // full blocks stray pooled pixels once the group's writes are complete
    wr_en = act && !full && (pool_convlayer_state ? pe_valid : pool_dout_st);
    busy = state != IDLE;
    done = state == DONE;
    case (state)
      IDLE:    state_nx = accept ? RUN : IDLE;
      RUN:     state_nx = wr_en && last ? DONE : last_in ? DRAIN : RUN;
      DRAIN:   state_nx = wr_en && last ? DONE : wdog_to ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      pool_featmap_size <= '0;
      pool_convlayer_state <= 1'b0;
      base_q <= '0;
      in_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= (state == IDLE && start && !ok) || wdog_to;
      if (accept) begin
        pool_featmap_size <= cfg_featmap_size;
        pool_convlayer_state <= cfg_layer;
        base_q <= cfg_out_base;
        in_cnt <= '0;
      end else if (run && pe_valid) in_cnt <= in_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_pool_layer_sched.sv
// tb_pool_layer_sched: directed self-checking bench for pool_layer_sched
module tb_pool_layer_sched;
  logic clk = 0, rst_n = 0, start = 0, cfg_layer = 0, pe_valid = 0, pool_dout_st = 0;
  logic [4:0] cfg_featmap_size = 0;
  logic [9:0] cfg_out_base = 0;
  logic pool_din_st, pool_convlayer_state, wr_en, busy, done, err;
  logic [4:0] pool_featmap_size;
  logic [9:0] wr_addr;
  pool_layer_sched dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg_featmap_size(cfg_featmap_size),
    .cfg_layer(cfg_layer),
    .cfg_out_base(cfg_out_base),
    .pe_valid(pe_valid),
    .pool_din_st(pool_din_st),
    .pool_featmap_size(pool_featmap_size),
    .pool_convlayer_state(pool_convlayer_state),
    .pool_dout_st(pool_dout_st),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .busy(busy),
    .done(done),
    .err(err)
  );
  always #5 clk = ~clk;
  int cyc = 0, din_n = 0, done_n = 0, err_n = 0, busy_n = 0;
  int done_cyc = 0, err_cyc = 0, last_wr_cyc = 0;
  logic prev_done = 0, done_busy = 0, post_busy = 0, err_busy = 0;
  logic [9:0] wq[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (prev_done) post_busy <= busy;
    prev_done <= done;
    if (pool_din_st) din_n <= din_n + 1;
    if (busy) busy_n <= busy_n + 1;
    if (wr_en) begin
      wq.push_back(wr_addr);
      last_wr_cyc <= cyc;
    end
    if (done) begin
      done_n <= done_n + 1;
      done_cyc <= cyc;
      done_busy <= busy;
    end
    if (err) begin
      err_n <= err_n + 1;
      err_cyc <= cyc;
      err_busy <= busy;
    end
  end
  int errs = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic s, input logic pv, input logic pd);
    start = s;
    pe_valid = pv;
    pool_dout_st = pd;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [4:0] n, input logic l, input logic [9:0] b);
    cfg_featmap_size = n;
    cfg_layer = l;
    cfg_out_base = b;
  endtask
  int s, b_din, b_wr, b_done, b_err, b_busy;
  task automatic mark();
    b_din = din_n;
    b_wr = wq.size();
    b_done = done_n;
    b_err = err_n;
    b_busy = busy_n;
    s = cyc;
  endtask
  initial begin
    repeat (3) drive(0, 0, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_din", 32'(pool_din_st), 0);
    check("rst_fsize", 32'(pool_featmap_size), 0);
    check("rst_layer", 32'(pool_convlayer_state), 0);
    check("rst_addr", 32'(wr_addr), 0);
    rst_n = 1;
    drive(0, 0, 0);
    // pool N=4: windows close on inputs 5,7,13,15; pooled pixel two cycles later
    cfg(4, 0, 10'h100);
    mark();
    drive(1, 0, 0);
    check("t1_busy_run", 32'(busy), 1);
    for (int k = 0; k < 24; k++) drive(0, k < 16, k == 7 || k == 9 || k == 15 || k == 17);
    check("t1_din", din_n - b_din, 16);
    check("t1_wr_n", wq.size() - b_wr, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_addr%0d", i), 32'(wq[b_wr + i]), 32'h100 + i);
    check("t1_last_wr", last_wr_cyc - s, 18);
    check("t1_done_n", done_n - b_done, 1);
    check("t1_done_lat", done_cyc - last_wr_cyc, 1);
    check("t1_done_busy", 32'(done_busy), 1);
    check("t1_busy_fall", 32'(post_busy), 0);
    check("t1_err", err_n - b_err, 0);
    check("t1_fsize", 32'(pool_featmap_size), 4);
    // bypass N=2 with address wrap
    cfg(2, 1, 10'h3FE);
    mark();
    drive(1, 0, 0);
    for (int k = 0; k < 8; k++) drive(0, k < 4, 0);
    check("t2_din", din_n - b_din, 0);
    check("t2_wr_n", wq.size() - b_wr, 4);
    check("t2_addr0", 32'(wq[b_wr]), 32'h3FE);
    check("t2_addr1", 32'(wq[b_wr + 1]), 32'h3FF);
    check("t2_addr2", 32'(wq[b_wr + 2]), 32'h000);
    check("t2_addr3", 32'(wq[b_wr + 3]), 32'h001);
    check("t2_done_cyc", done_cyc - s, 5);
    check("t2_done_n", done_n - b_done, 1);
    check("t2_layer", 32'(pool_convlayer_state), 1);
    // invalid configs
    cfg(5, 0, 10'h000);
    mark();
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    check("t3_err5", err_n - b_err, 1);
    check("t3_err5_lat", err_cyc - s, 1);
    cfg(30, 0, 10'h000);
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    check("t3_err_n", err_n - b_err, 2);
    check("t3_busy", busy_n - b_busy, 0);
    check("t3_wr", wq.size() - b_wr, 0);
    check("t3_fsize", 32'(pool_featmap_size), 2);
    // reset in the middle of an N=28 run
    cfg(28, 0, 10'h200);
    drive(1, 0, 0);
    for (int k = 0; k < 100; k++) drive(0, 1, 0);
    rst_n = 0;
    mark();
    drive(0, 1, 1);
    check("t4_busy", 32'(busy), 0);
    check("t4_din", 32'(pool_din_st), 0);
    check("t4_wr_en", 32'(wr_en), 0);
    check("t4_done", 32'(done), 0);
    check("t4_err", 32'(err), 0);
    check("t4_fsize", 32'(pool_featmap_size), 0);
    check("t4_layer", 32'(pool_convlayer_state), 0);
    check("t4_addr", 32'(wr_addr), 0);
    drive(0, 0, 0);
    rst_n = 1;
    drive(0, 0, 0);
    check("t4_no_pulse", done_n - b_done + err_n - b_err, 0);
    cfg(2, 0, 10'h055);
    mark();
    drive(1, 0, 0);
    for (int k = 0; k < 10; k++) drive(0, k < 4, k == 5);
    check("t4_din2", din_n - b_din, 4);
    check("t4_wr_n", wq.size() - b_wr, 1);
    check("t4_addr2", 32'(wq[b_wr]), 32'h055);
    check("t4_done_cyc", done_cyc - s, 7);
    // stray output in IDLE, start during RUN, extra inputs after the last one
    cfg(2, 0, 10'h0A0);
    mark();
    drive(0, 0, 1);
    s = cyc;
    drive(1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      if (k == 1) cfg(4, 1, 10'h300);
      drive(k == 1, k < 6, k == 5);
    end
    check("t5_wr_n", wq.size() - b_wr, 1);
    check("t5_addr", 32'(wq[b_wr]), 32'h0A0);
    check("t5_din", din_n - b_din, 4);
    check("t5_busy_n", busy_n - b_busy, 7);
    check("t5_done_n", done_n - b_done, 1);
    check("t5_fsize", 32'(pool_featmap_size), 2);
    check("t5_layer", 32'(pool_convlayer_state), 0);
`ifdef POOL_SCHED_WDOG_EN
    cfg(4, 0, 10'h000);
    mark();
    drive(1, 0, 0);
    for (int k = 0; k < 40; k++) drive(0, k < 16, 0);
    check("t6_err_n", err_n - b_err, 1);
    check("t6_err_cyc", err_cyc - s, 33);
    check("t6_err_busy", 32'(err_busy), 0);
    check("t6_done_n", done_n - b_done, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
